// File: rtl/conv_window_sequencer_if.sv
// Operand/handshake bundle between the window sequencer (master) and the
// matrix accelerator (slave).
interface conv_window_sequencer_if #(
  parameter int BIT_LENGTH = 8,
  parameter int PORT_COUNT = 3
);
  logic [PORT_COUNT*BIT_LENGTH-1:0] multiplier_out;
  logic [PORT_COUNT*BIT_LENGTH-1:0] multiplicand_out;
  logic [PORT_COUNT-1:0]            mStart;
  logic [PORT_COUNT-1:0]            mReady;
  logic                             finalAdd;
  logic                             finalReady;
  logic [2*BIT_LENGTH-1:0]          finalAccumulate;

  modport master (
    output multiplier_out, multiplicand_out, mStart, finalAdd,
    input  mReady, finalReady, finalAccumulate
  );

  modport slave (
    input  multiplier_out, multiplicand_out, mStart, finalAdd,
    output mReady, finalReady, finalAccumulate
  );
endinterface

// File: rtl/conv_window_sequencer.sv
// Issues a 3x3 window/kernel to the accelerator row by row, then captures the final sum.
// Optional wait timeout with sticky err: define CONV_SEQ_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | banks writable, waiting for start
// ISSUE  | drive row operands, pulse mStart on all lanes, clear ready mask
// WAIT_M | collect per-lane mReady into the sticky mask
// FINAL  | pulse finalAdd
// WAIT_F | wait for finalReady, capture finalAccumulate
// DONE   | pulse result_valid
module conv_window_sequencer #(
  parameter int BIT_LENGTH     = 8,
  parameter int PORT_COUNT     = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    wr_en,
  input  logic                    wr_sel,
  input  logic [3:0]              wr_addr,
  input  logic [BIT_LENGTH-1:0]   wr_data,
  input  logic                    start,
  output logic                    busy,
  conv_window_sequencer_if.master acc,
  output logic [2*BIT_LENGTH-1:0] result,
  output logic                    result_valid,
  output logic                    err
);
  localparam int ELEMS = PORT_COUNT * PORT_COUNT;
  localparam int ROW_W = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1;
  localparam int IDX_W = $clog2(ELEMS);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(PORT_COUNT - 1);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 256) begin : gBadTimeout
    $error("TIMEOUT_CYCLES must fit the 8-bit wait counter");
  end

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_M, FINAL, WAIT_F, DONE} state_t;

  state_t                         state, stateNext;
  logic [BIT_LENGTH-1:0]          kernel [ELEMS];
  logic [BIT_LENGTH-1:0]          window [ELEMS];
  logic [ROW_W-1:0]               rowIdx;
  logic [PORT_COUNT-1:0]          readyMask, maskNext;
  logic [IDX_W-1:0]               opIdx;
  logic                           timeout;
  logic [PORT_COUNT*BIT_LENGTH-1:0] multC, mcandC;
  logic [PORT_COUNT-1:0]          mStartC;
  logic                           finalAddC, resultValidC, busyC;

  // Writes are only honoured while idle so a pass always sees a stable window.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < ELEMS; i++) begin
        kernel[i] <= '0;
        window[i] <= '0;
      end
    end else if (wr_en && state == IDLE && int'(wr_addr) < ELEMS) begin
      if (wr_sel) window[IDX_W'(wr_addr)] <= wr_data;
      else        kernel[IDX_W'(wr_addr)] <= wr_data;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= IDLE;
      rowIdx    <= '0;
      readyMask <= '0;
      result    <= '0;
    end else begin
      state <= stateNext;
      case (state)
        IDLE:   rowIdx <= '0;
        ISSUE:  readyMask <= '0;
        WAIT_M: begin
          readyMask <= maskNext;
          if (stateNext == ISSUE) rowIdx <= rowIdx + ROW_W'(1);
        end
        WAIT_F: if (acc.finalReady) result <= acc.finalAccumulate;
        default: ;
      endcase
    end
  end

  always_comb begin
    stateNext    = state;
    maskNext     = readyMask | acc.mReady;
    mStartC      = '0;
    finalAddC    = 1'b0;
    resultValidC = 1'b0;
    busyC        = 1'b1;
    multC        = '0;
    mcandC       = '0;
    opIdx        = '0;
    case (state)
      IDLE: begin
        busyC = 1'b0;
        if (start) stateNext = ISSUE;
      end
      ISSUE: begin
        mStartC   = '1;
        stateNext = WAIT_M;
      end
      WAIT_M: begin
        // A lane completing on the same cycle as the last sibling still counts.
        if (&maskNext)    stateNext = (rowIdx == LAST_ROW) ? FINAL : ISSUE;
        else if (timeout) stateNext = DONE;
      end
      FINAL: begin
        finalAddC = 1'b1;
        stateNext = WAIT_F;
      end
      WAIT_F: begin
        if (acc.finalReady || timeout) stateNext = DONE;
      end
      DONE: begin
        resultValidC = 1'b1;
        stateNext    = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    if (state == ISSUE || state == WAIT_M) begin
      for (int i = 0; i < PORT_COUNT; i++) begin
        opIdx = IDX_W'(int'(rowIdx) * PORT_COUNT + i);
        multC[i*BIT_LENGTH +: BIT_LENGTH]  = window[opIdx];
        mcandC[i*BIT_LENGTH +: BIT_LENGTH] = kernel[opIdx];
      end
    end
  end

`ifdef CONV_SEQ_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LOAD = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] waitCnt;
  logic       errReg;
  logic       waiting;

  assign waiting = (state == WAIT_M) || (state == WAIT_F);
  assign timeout = waiting && (waitCnt == 8'd0);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      waitCnt <= TIMEOUT_LOAD;
      errReg  <= 1'b0;
    end else begin
      if (stateNext != state)           waitCnt <= TIMEOUT_LOAD;
      else if (waiting && waitCnt != 0) waitCnt <= waitCnt - 8'd1;
      // A real completion on the expiry cycle wins over the timeout.
      if (timeout && stateNext == DONE && !(state == WAIT_F && acc.finalReady))
        errReg <= 1'b1;
    end
  end
  assign err = errReg;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  assign busy                 = busyC;
  assign result_valid         = resultValidC;
  assign acc.mStart           = mStartC;
  assign acc.finalAdd         = finalAddC;
  assign acc.multiplier_out   = multC;
  assign acc.multiplicand_out = mcandC;
endmodule

// File: doc/conv_window_sequencer.md
# conv_window_sequencer

Upstream operand sequencer for the matrix accelerator in the convolution datapath. Holds a 3x3 kernel and a 3x3 pixel window in local registers. On `start`, it issues the window to the accelerator one row at a time: three lanes per row, each lane a multiplier/multiplicand pair. It then triggers the final accumulate and returns the captured sum with a one-cycle valid pulse.

## Interface
Parameters:
- `BIT_LENGTH`, 8: operand width per lane.
- `PORT_COUNT`, 3: lanes per row, which is also the number of rows.
- `TIMEOUT_CYCLES`, 255: wait limit used only with `CONV_SEQ_TIMEOUT_EN`.

Ports:
- `Clk` in 1: single clock, rising edge.
- `Rst` in 1: asynchronous, active-high reset.
- `wr_en` in 1: operand register write strobe.
- `wr_sel` in 1: 0 = kernel bank, 1 = window bank.
- `wr_addr` in 4: element index 0..8, row-major.
- `wr_data` in `BIT_LENGTH`: element value.
- `start` in 1: begin a convolution pass.
- `busy` out 1: pass in progress.
- `multiplier_out` out `PORT_COUNT*BIT_LENGTH`: window elements; lane i at `[i*BIT_LENGTH +: BIT_LENGTH]`.
- `multiplicand_out` out `PORT_COUNT*BIT_LENGTH`: kernel elements, same packing.
- `mStart` out `PORT_COUNT`: per-lane multiply start.
- `mReady` in `PORT_COUNT`: per-lane multiply done.
- `finalAdd` out 1: final accumulate trigger.
- `finalReady` in 1: accumulator result valid.
- `finalAccumulate` in `2*BIT_LENGTH`: accumulator sum.
- `result` out `2*BIT_LENGTH`: captured sum.
- `result_valid` out 1: one-cycle pulse.
- `err` out 1: sticky timeout flag; held 0 when the macro is off.

## Operation
- Register banks: two banks of 9 x `BIT_LENGTH`.
  - Writes take effect only when `wr_en` is high and the FSM is in IDLE.
  - `wr_addr` > 8 is ignored.
  - Writes attempted during a pass are dropped, not queued.
  - Bank contents are cleared to 0 by `Rst` and persist across passes.
- FSM states:
  - IDLE: `start` moves to ISSUE; row counter set to 0.
  - ISSUE: drive row r operands; `mStart` = all ones for exactly this cycle; clear the sticky ready mask; go to WAIT_M.
  - WAIT_M: OR `mReady` into the sticky mask each cycle. When the mask is all ones: if r < 2, increment r and go to ISSUE; else go to FINAL.
  - FINAL: `finalAdd` = 1 for one cycle; go to WAIT_F.
  - WAIT_F: on `finalReady`, register `finalAccumulate` into `result`; go to DONE.
  - DONE: `result_valid` = 1 for one cycle; go to IDLE.
- Operands for row r:
  - `multiplier_out` lane i = window[r*3+i].
  - `multiplicand_out` lane i = kernel[r*3+i].
  - Both are held stable from ISSUE through the end of that row's WAIT_M.
  - Both are 0 in IDLE, FINAL, WAIT_F and DONE.
- `busy` is 1 in every state except IDLE.
- `start` while busy is ignored. `start` in the same cycle as `wr_en` (in IDLE): the write commits and the pass uses the new value.
- Lanes that complete early:
  - An `mReady` bit that arrives before its siblings is latched in the mask.
  - Lanes may complete in any order and on any cycle.
- An `mReady` arriving during ISSUE is ignored; the mask clears in that cycle.
- `result` holds its value until the next capture.
- Arithmetic: no local math. `result` is the full `2*BIT_LENGTH` accumulator value, unmodified.

## Timing
- Reset values of outputs:
  - `busy`, `mStart`, `finalAdd`, `result_valid`, `err`: 0.
  - `result`, `multiplier_out`, `multiplicand_out`: 0.
  - FSM in IDLE.
- `Rst` mid-pass aborts immediately: all outputs return to reset values, and register banks are also cleared.
- Latency, with `start` sampled at edge 0, per-row multiply latency k cycles after `mStart`, and final latency f cycles after `finalAdd`:
  - ISSUE row 0 at cycle 1.
  - `result_valid` at cycle 3*(1+k) + 1 + f + 1.
  - Minimum case (k=1, f=1): `result_valid` at cycle 9.
- Back-to-back: `start` may be asserted in the same cycle as `result_valid`. It is ignored because the FSM is in DONE. The earliest accepted `start` is the next cycle.

## Configuration
- `CONV_SEQ_TIMEOUT_EN` defined:
  - An 8-bit wait counter runs in WAIT_M and WAIT_F and resets on every state entry.
  - Reaching `TIMEOUT_CYCLES` sets `err` (sticky until `Rst`) and goes to DONE.
  - `result_valid` still pulses, and `result` is left unchanged.
- Not defined:
  - No counter is built; `err` is tied 0.
  - WAIT_M and WAIT_F wait indefinitely.

## Test plan
- Load kernel all 1s and window 1..9; `start`; model with mReady 1 cycle after `mStart` and finalReady 1 cycle after `finalAdd`, returning the sum of products -> three `mStart` pulses with lanes {1,2,3}/{4,5,6}/{7,8,9}, one `finalAdd`, `result` = 45, `result_valid` at cycle 9.
- Staggered mReady in row 0 (lane 2 at +1, lane 0 at +3, lane 1 at +5) -> row 1 ISSUE exactly one cycle after lane 1's `mReady`; no extra `mStart`.
- Write window[4]=99 while busy -> pass computes with the old value; after IDLE, a re-run reflects 99 only if rewritten.
- Assert `Rst` during WAIT_M of row 1 -> all outputs 0 asynchronously; subsequent load of kernel 2s and window 3s -> `result` = 54.
- With `CONV_SEQ_TIMEOUT_EN` and `TIMEOUT_CYCLES`=10, never assert mReady -> `err`=1 and a single `result_valid` pulse, `result` unchanged; without the macro, `busy` stays 1 for 1000 cycles.
